// File: rtl/bitstream_reader.sv
// bitstream_reader: extracts variable-length MSB-first fields from a stream of WIDTH-bit words,
// with byte alignment and a 2*WIDTH-bit elastic buffer so fields may straddle words.
module bitstream_reader #(
    parameter int WIDTH  = 32,
    parameter int MAXLEN = 16,
    parameter int LENW   = $clog2(MAXLEN + 1),
    parameter int CNTW   = 16
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           req_valid,
    input  logic [LENW-1:0]                req_len,
    input  logic                           req_align,
    output logic                           req_ready,
    output logic [MAXLEN-1:0]              out_data,
    output logic                           out_valid,
    output logic [$clog2(2*WIDTH+1)-1:0]   bit_count,
    output logic [CNTW-1:0]                bits_consumed
);
    localparam int BUF = 2 * WIDTH;
    localparam int BCW = $clog2(BUF + 1);
    logic [BUF-1:0]  buffer, buffer_next;
    logic [LENW-1:0] len_clip;
    logic [2:0]      len_align;
    logic [BCW-1:0]  len, remaining;
    logic            accept, load;
    always_comb begin
        len_clip    = (req_len > LENW'(MAXLEN)) ? LENW'(MAXLEN) : req_len;
        len_align   = 3'd0 - bits_consumed[2:0];
        len         = req_align ? BCW'(len_align) : BCW'(len_clip);
        in_ready    = !flush && bit_count <= BCW'(WIDTH);
        req_ready   = !nrst && !flush && bit_count >= len;
        accept      = req_valid && req_ready;
        load        = in_valid && in_ready;
        remaining   = bit_count - (accept ? len : '0);
        // the new word lands right after whatever survives this cycle's consume
        buffer_next = (accept ? buffer << len : buffer)
                    | (load ? {in_data, {WIDTH{1'b0}}} >> remaining : '0);
    end
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            buffer        <= '0;
            bit_count     <= '0;
            bits_consumed <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
        end else if (flush) begin
            buffer        <= '0;
            bit_count     <= '0;
            bits_consumed <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
        end else begin
            buffer    <= buffer_next;
            bit_count <= remaining + (load ? BCW'(WIDTH) : '0);
            out_valid <= accept;
            if (accept) begin
                out_data      <= buffer[BUF-1 -: MAXLEN] >> (BCW'(MAXLEN) - len);
                bits_consumed <= bits_consumed + CNTW'(len);
            end
        end
    end
endmodule

// File: tb/tb_bitstream_reader.sv
// tb_bitstream_reader: directed and random checks of bitstream_reader against a bit-queue model.
module tb_bitstream_reader;
    logic        clk = 0, nrst = 1, flush = 0, in_valid = 0, req_valid = 0, req_align = 0;
    logic [31:0] in_data = 0;
    logic [4:0]  req_len = 0;
    logic        in_ready, req_ready, out_valid;
    logic [15:0] out_data, bits_consumed, g;
    logic [6:0]  bit_count;
    int          checks = 0, errors = 0;
    bit          q[$];
    int          consumed = 0;

    bitstream_reader dut (
        .clk(clk), .nrst(nrst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .req_valid(req_valid), .req_len(req_len), .req_align(req_align),
        .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid),
        .bit_count(bit_count), .bits_consumed(bits_consumed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock of stimulus; the queue holds exactly the unread bits in stream order
    task automatic step(input logic iv, input logic [31:0] d, input logic rv, input int len,
                        input logic al, input logic fl, output logic [15:0] got);
        int l;
        logic ein, erq, acc;
        logic [15:0] ed;
        in_valid = iv; in_data = d; req_valid = rv; req_len = 5'(len); req_align = al; flush = fl;
        #1;
        l   = al ? (8 - consumed % 8) % 8 : (len > 16 ? 16 : len);
        ein = !fl && q.size() <= 32;
        erq = !fl && q.size() >= l;
        acc = rv && erq;
        chk("in_ready", in_ready, ein);
        chk("req_ready", req_ready, erq);
        ed = 0;
        if (fl) begin
            q.delete();
            consumed = 0;
        end else begin
            if (acc) begin
                for (int i = 0; i < l; i++) ed = {ed[14:0], q.pop_front()};
                consumed += l;
            end
            if (iv && ein) for (int i = 31; i >= 0; i--) q.push_back(d[i]);
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, acc);
        if (acc) chk("out_data", out_data, ed);
        chk("bit_count", bit_count, q.size());
        chk("bits_consumed", bits_consumed, consumed % 65536);
        got = out_data;
        in_valid = 0; req_valid = 0; req_align = 0; flush = 0; req_len = 0;
    endtask

    task automatic ld(input logic [31:0] w);
        logic [15:0] x;
        step(1'b1, w, 1'b0, 0, 1'b0, 1'b0, x);
    endtask

    task automatic rd(input int len, output logic [15:0] x);
        step(1'b0, 32'h0, 1'b1, len, 1'b0, 1'b0, x);
    endtask

    task automatic algn(output logic [15:0] x);
        step(1'b0, 32'h0, 1'b1, 0, 1'b1, 1'b0, x);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_consumed", bits_consumed, 0);
        nrst = 0;

        ld(32'hB4EADEFB);
        rd(4, g);  chk("w1_len4", g, 16'h000B);
        rd(12, g); chk("w1_len12", g, 16'h04EA);
        rd(3, g);  chk("w1_len3", g, 16'h0006);
        algn(g);   chk("w1_align", g, 16'h001E);
        rd(8, g);  chk("w1_len8", g, 16'h00FB);
        chk("w1_consumed", bits_consumed, 32);
        chk("w1_count", bit_count, 0);

        ld(32'h12345678);
        ld(32'h9ABCDEF0);
        rd(12, g); chk("w2_len12", g, 16'h0123);
        rd(16, g); chk("w2_len16a", g, 16'h4567);
        rd(16, g); chk("w2_span", g, 16'h89AB);
        chk("w2_count", bit_count, 20);

        #2 nrst = 1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_count", bit_count, 0);
        chk("arst_consumed", bits_consumed, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_req_ready", req_ready, 0);
        @(negedge clk) nrst = 0;
        q.delete();
        consumed = 0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_count", bit_count, 0);

        ld(32'hCAFEF00D);
        rd(16, g);
        rd(13, g);
        chk("starve_count", bit_count, 3);
        step(1'b0, 32'h0, 1'b1, 8, 1'b0, 1'b0, g);
        step(1'b1, 32'h3C000000, 1'b1, 8, 1'b0, 1'b0, g);
        rd(8, g); chk("starve_data", g, 16'h00A7);

        step(1'b1, 32'hFFFFFFFF, 1'b1, 4, 1'b0, 1'b1, g);
        chk("flush_count", bit_count, 0);
        chk("flush_consumed", bits_consumed, 0);

        ld(32'h11223344);
        ld(32'h55667788);
        rd(0, g);  chk("len0_data", g, 16'h0000);
        chk("len0_count", bit_count, 64);
        rd(16, g); chk("e_len16", g, 16'h1122);
        rd(8, g);  chk("e_len8", g, 16'h0033);
        algn(g);   chk("align_noop", g, 16'h0000);
        chk("align_noop_count", bit_count, 40);
        rd(8, g);  chk("e_len8b", g, 16'h0044);
        step(1'b1, 32'hAABBCCDD, 1'b1, 16, 1'b0, 1'b0, g);
        chk("load_read_data", g, 16'h5566);
        chk("load_read_count", bit_count, 48);
        rd(31, g); chk("clamp_len", g, 16'h7788);

        for (int n = 0; n < 400; n++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 20)), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 39) == 0, g);

        step(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b1, g);
        for (int n = 0; n < 2100; n++) begin
            ld($urandom);
            rd(16, g);
            rd(16, g);
        end
        chk("wrap_consumed", bits_consumed, (2100 * 32) % 65536);
        ld($urandom);
        rd(3, g);
        algn(g);
        chk("wrap_align_count", bit_count, 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
